uba_intr_arb: RTL and testbench
===============================

// Module: uba_intr_arb
//
// PURPOSE
//   Interrupt arbiter/scheduler for one UBA. Collects BR7..BR4 requests from
//   the UBA devices and produces the HI/LO pending bits for the UBA status
//   register. Maps pending requests onto CPU PI levels using the PIH and PIL
//   assignments. Sequences the interrupt-vector acknowledge handshake:
//   picks one device, grants it, then collects its vector or times out.
//
// PARAMETERS
//   NDEV    4   number of UBA devices (1..8)
//   TMOCNT  63  cycles to wait for devVECTVLD before forcing a timeout
//
// PORTS
//   clk         in   1       clock
//   rst_n       in   1       reset, asynchronous, active-low
//   devINTR     in   4*NDEV  device d requests: bit[4d+3]=BR7 .. bit[4d]=BR4
//   statPIH     in   3       hi-level PI assignment; 0 = disabled
//   statPIL     in   3       lo-level PI assignment; 0 = disabled
//   statINI     in   1       UBA initialize pulse; aborts any acknowledge
//   statINTHI   out  1       any BR7/BR6 request pending (to UBASR HI)
//   statINTLO   out  1       any BR5/BR4 request pending (to UBASR LO)
//   busINTR     out  7       PI request to CPU; bit n-1 = PI level n
//   ackREQ      in   1       CPU vector-read request (1-cycle pulse)
//   ackPI       in   3       PI level being acknowledged
//   ackBUSY     out  1       arbiter not IDLE; ackREQ is ignored
//   ackDONE     out  1       1-cycle pulse; ackVECT is valid
//   ackVECT     out  16      returned vector; 0 = none or timeout
//   devACK      out  NDEV    one-hot grant to the selected device
//   devACKBR    out  2       granted BR: 3=BR7, 2=BR6, 1=BR5, 0=BR4
//   devVECTVLD  in   1       granted device drives devVECT this cycle
//   devVECT     in   16      vector from the granted device (muxed upstream)
//   setTMO      out  1       1-cycle pulse on vector timeout (to UBASR TMO)
//
// BEHAVIOUR
//   - Reset: all outputs 0, state IDLE, wait counter 0, rr pointer NDEV-1
//     (device 0 is checked first).
//   - statINTHI/statINTLO: registered OR of BR7|BR6 and BR5|BR4 over all
//     devices. One cycle of latency.
//   - busINTR: registered. Bit PIH-1 is set if statINTHI and PIH!=0.
//     Bit PIL-1 is set if statINTLO and PIL!=0. PIH==PIL sets a single bit.
//   - FSM states: IDLE, GRANT, WAIT, DONE.
//   - IDLE, ackREQ=1: hiMatch = (ackPI==PIH && PIH!=0 && any hi request);
//     loMatch is the same using PIL and lo requests. Inputs are sampled
//     this cycle.
//       - hiMatch wins over loMatch.
//       - No match -> DONE with ackVECT=0, no grant.
//       - Match -> latch selection -> GRANT.
//   - Selection: pick the highest BR in the winning group (7>6, 5>4). Among
//     devices at that BR, pick round-robin starting at rr pointer+1,
//     modulo NDEV.
//   - GRANT (1 cycle): devACK/devACKBR are driven. Wait counter cleared.
//     Go to WAIT.
//   - devACK/devACKBR stay asserted through GRANT and WAIT, and drop on
//     entry to DONE.
//   - WAIT: devVECTVLD=1 latches devVECT into ackVECT, sets the rr pointer
//     to the granted device, and goes to DONE. A device dropping its
//     request does not end the wait.
//   - WAIT timeout: when the counter reaches TMOCNT with no devVECTVLD,
//     ackVECT=0, setTMO pulses, rr pointer is unchanged, go to DONE.
//   - DONE: ackDONE=1 for exactly 1 cycle, then IDLE. ackVECT holds until
//     the next accepted ackREQ.
//   - ackBUSY = (state != IDLE).
//   - Latency: ackREQ at cycle N -> devACK at N+1 -> devVECTVLD at cycle M
//     -> ackDONE at M+1. Fastest round trip: ackDONE at N+3.
//   - statINI in GRANT/WAIT: drop devACK, ackVECT=0, go to DONE, no setTMO,
//     rr pointer unchanged.
//   - statINI in IDLE or DONE has no effect on the FSM.
//   - devVECTVLD outside WAIT is ignored.
//   - Async reset mid-handshake returns to reset values immediately.
//
// TESTING
//   1 Reset: rst_n=0 with requests active -> every output 0. After release,
//     statINTHI/LO follow one cycle later.
//   2 Mapping: dev1 BR6, PIH=3, PIL=5 -> statINTHI=1, busINTR=7'b0000100.
//     Add dev2 BR4 -> busINTR=7'b0010100.
//   3 Ack: dev1 BR6, ackREQ with ackPI=3, dev replies 0o254 two cycles after
//     devACK -> devACK=0010, devACKBR=2, ackDONE with ackVECT=16'o254.
//   4 Priority/RR: dev0 and dev2 on BR7, dev3 on BR6. Three acks ->
//     grants dev0, then dev2, then dev0; dev3 is never granted while any
//     BR7 is pending.
//   5 Timeout: grant with no devVECTVLD -> setTMO and ackDONE pulse after
//     TMOCNT WAIT cycles with ackVECT=0; the next ack re-grants the same
//     device.
//   6 Mismatch/abort: ackPI=2 with PIH=3, PIL=5 -> ackDONE at N+1, vector 0,
//     no devACK. statINI during WAIT -> ackDONE, no setTMO.

Source files
------------

// File: rtl/uba_intr_arb.sv
// UBA interrupt arbiter: collects BR7..BR4 device requests, reports HI/LO
// pending status, maps them onto CPU PI levels and sequences the
// vector-acknowledge handshake (select, grant, collect vector or time out).
module uba_intr_arb #(
    parameter int NDEV   = 4,
    parameter int TMOCNT = 63
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4*NDEV-1:0] devINTR,
    input  logic [2:0]        statPIH,
    input  logic [2:0]        statPIL,
    input  logic              statINI,
    output logic              statINTHI,
    output logic              statINTLO,
    output logic [6:0]        busINTR,
    input  logic              ackREQ,
    input  logic [2:0]        ackPI,
    output logic              ackBUSY,
    output logic              ackDONE,
    output logic [15:0]       ackVECT,
    output logic [NDEV-1:0]   devACK,
    output logic [1:0]        devACKBR,
    input  logic              devVECTVLD,
    input  logic [15:0]       devVECT,
    output logic              setTMO
);

    localparam int DW = (NDEV > 1) ? $clog2(NDEV) : 1;
    localparam int CW = $clog2(TMOCNT + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t          state_r;
    logic [DW-1:0]   rr_r;
    logic [CW-1:0]   cnt_r;
    logic            hi_r;
    logic            lo_r;
    logic [6:0]      bus_r;
    logic            ack_done_r;
    logic [15:0]     ack_vect_r;
    logic [NDEV-1:0] dev_ack_r;
    logic [1:0]      dev_ack_br_r;
    logic            set_tmo_r;

    logic [NDEV-1:0] br_mask_s [4];
    logic            hi_any_s;
    logic            lo_any_s;
    logic            hi_match_s;
    logic            lo_match_s;
    logic [1:0]      sel_br_s;
    logic [NDEV-1:0] sel_mask_s;
    logic [DW-1:0]   sel_dev_s;
    logic [NDEV-1:0] sel_onehot_s;
    logic            found_s;
    logic [DW:0]     idx_s;
    logic [6:0]      bus_s;

    // Split the request vector into per-BR device masks and summarise them.
    always_comb begin
        for (int b = 0; b < 4; b++) begin
            for (int d = 0; d < NDEV; d++) begin
                br_mask_s[b][d] = devINTR[4*d+b];
            end
        end
        hi_any_s = (|br_mask_s[3]) | (|br_mask_s[2]);
        lo_any_s = (|br_mask_s[1]) | (|br_mask_s[0]);
        bus_s    = 7'd0;
        bus_s    = (hi_any_s && statPIH != 3'd0) ? (bus_s | (7'd1 << (statPIH - 3'd1))) : bus_s;
        bus_s    = (lo_any_s && statPIL != 3'd0) ? (bus_s | (7'd1 << (statPIL - 3'd1))) : bus_s;
    end

    // Decide which group answers the acknowledge and pick the device:
    // highest BR in the group, then round-robin starting after rr_r.
    always_comb begin
        hi_match_s = ackREQ && (ackPI == statPIH) && (statPIH != 3'd0) && hi_any_s;
        lo_match_s = ackREQ && (ackPI == statPIL) && (statPIL != 3'd0) && lo_any_s;
        if (hi_match_s) begin
            sel_br_s = (|br_mask_s[3]) ? 2'd3 : 2'd2;
        end else if (lo_match_s) begin
            sel_br_s = (|br_mask_s[1]) ? 2'd1 : 2'd0;
        end else begin
            sel_br_s = 2'd0;
        end
        sel_mask_s = br_mask_s[sel_br_s];
        sel_dev_s  = '0;
        found_s    = 1'b0;
        idx_s      = '0;
        for (int i = 0; i < NDEV; i++) begin
            idx_s     = {1'b0, rr_r} + (DW+1)'(i + 1);
            idx_s     = (idx_s >= (DW+1)'(NDEV)) ? (idx_s - (DW+1)'(NDEV)) : idx_s;
            sel_dev_s = (!found_s && sel_mask_s[idx_s[DW-1:0]]) ? idx_s[DW-1:0] : sel_dev_s;
            found_s   = found_s | sel_mask_s[idx_s[DW-1:0]];
        end
        for (int d = 0; d < NDEV; d++) begin
            sel_onehot_s[d] = (sel_dev_s == DW'(d));
        end
    end

    // Status/PI registers and the acknowledge sequencer with its outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            rr_r         <= DW'(NDEV - 1);
            cnt_r        <= '0;
            hi_r         <= 1'b0;
            lo_r         <= 1'b0;
            bus_r        <= 7'd0;
            ack_done_r   <= 1'b0;
            ack_vect_r   <= 16'd0;
            dev_ack_r    <= '0;
            dev_ack_br_r <= 2'd0;
            set_tmo_r    <= 1'b0;
        end else begin
            hi_r       <= hi_any_s;
            lo_r       <= lo_any_s;
            bus_r      <= bus_s;
            ack_done_r <= 1'b0;
            set_tmo_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (ackREQ) begin
                        ack_vect_r <= 16'd0;
                        if (hi_match_s || lo_match_s) begin
                            dev_ack_r    <= sel_onehot_s;
                            dev_ack_br_r <= sel_br_s;
                            state_r      <= ST_GRANT;
                        end else begin
                            ack_done_r <= 1'b1;
                            state_r    <= ST_DONE;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_GRANT: begin
                    cnt_r <= '0;
                    if (statINI) begin
                        dev_ack_r    <= '0;
                        dev_ack_br_r <= 2'd0;
                        ack_done_r   <= 1'b1;
                        state_r      <= ST_DONE;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (statINI) begin
                        dev_ack_r    <= '0;
                        dev_ack_br_r <= 2'd0;
                        ack_vect_r   <= 16'd0;
                        ack_done_r   <= 1'b1;
                        state_r      <= ST_DONE;
                    end else if (devVECTVLD) begin
                        ack_vect_r   <= devVECT;
                        rr_r         <= sel_dev_from_ack(dev_ack_r);
                        dev_ack_r    <= '0;
                        dev_ack_br_r <= 2'd0;
                        ack_done_r   <= 1'b1;
                        state_r      <= ST_DONE;
                    end else if (cnt_r == CW'(TMOCNT - 1)) begin
                        dev_ack_r    <= '0;
                        dev_ack_br_r <= 2'd0;
                        ack_vect_r   <= 16'd0;
                        ack_done_r   <= 1'b1;
                        set_tmo_r    <= 1'b1;
                        state_r      <= ST_DONE;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Index of the single set bit in the grant vector.
    function automatic logic [DW-1:0] sel_dev_from_ack(input logic [NDEV-1:0] onehot);
        logic [DW-1:0] res;
        res = '0;
        for (int d = 0; d < NDEV; d++) begin
            res = onehot[d] ? DW'(d) : res;
        end
        return res;
    endfunction

    assign statINTHI = hi_r;
    assign statINTLO = lo_r;
    assign busINTR   = bus_r;
    assign ackBUSY   = (state_r != ST_IDLE);
    assign ackDONE   = ack_done_r;
    assign ackVECT   = ack_vect_r;
    assign devACK    = dev_ack_r;
    assign devACKBR  = dev_ack_br_r;
    assign setTMO    = set_tmo_r;

endmodule

// File: tb/tb_uba_intr_arb.sv
// Self-checking bench for uba_intr_arb: directed scenarios followed by
// randomized requests/acknowledges checked against a transaction-level model.
module tb_uba_intr_arb;

    localparam int NDEV   = 4;
    localparam int TMOCNT = 63;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] devINTR;
    logic [2:0]  statPIH;
    logic [2:0]  statPIL;
    logic        statINI;
    logic        statINTHI;
    logic        statINTLO;
    logic [6:0]  busINTR;
    logic        ackREQ;
    logic [2:0]  ackPI;
    logic        ackBUSY;
    logic        ackDONE;
    logic [15:0] ackVECT;
    logic [3:0]  devACK;
    logic [1:0]  devACKBR;
    logic        devVECTVLD;
    logic [15:0] devVECT;
    logic        setTMO;

    int n_checks = 0;
    int n_pass   = 0;
    int model_rr = NDEV - 1;

    uba_intr_arb #(.NDEV(NDEV), .TMOCNT(TMOCNT)) dut (
        .clk(clk), .rst_n(rst_n), .devINTR(devINTR), .statPIH(statPIH),
        .statPIL(statPIL), .statINI(statINI), .statINTHI(statINTHI),
        .statINTLO(statINTLO), .busINTR(busINTR), .ackREQ(ackREQ),
        .ackPI(ackPI), .ackBUSY(ackBUSY), .ackDONE(ackDONE), .ackVECT(ackVECT),
        .devACK(devACK), .devACKBR(devACKBR), .devVECTVLD(devVECTVLD),
        .devVECT(devVECT), .setTMO(setTMO)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int br_any(input logic [15:0] intr, input int b);
        int r = 0;
        for (int d = 0; d < NDEV; d++) if (intr[4*d+b]) r = 1;
        return r;
    endfunction

    function automatic int exp_bus(input logic [15:0] intr, input int pih, input int pil);
        int e = 0;
        if ((br_any(intr, 3) || br_any(intr, 2)) && pih != 0) e = e | (1 << (pih - 1));
        if ((br_any(intr, 1) || br_any(intr, 0)) && pil != 0) e = e | (1 << (pil - 1));
        return e;
    endfunction

    // Which device/BR the arbiter should grant for this acknowledge.
    task automatic predict(input logic [15:0] intr, input int pih, input int pil,
                           input int pi, output int hit, output int dev, output int br);
        int found = 0;
        hit = 0; dev = 0; br = 0;
        if (pi == pih && pih != 0 && (br_any(intr, 3) || br_any(intr, 2))) begin
            hit = 1; br = br_any(intr, 3) ? 3 : 2;
        end else if (pi == pil && pil != 0 && (br_any(intr, 1) || br_any(intr, 0))) begin
            hit = 1; br = br_any(intr, 1) ? 1 : 0;
        end
        if (hit != 0) begin
            for (int k = 1; k <= NDEV; k++) begin
                int d = (model_rr + k) % NDEV;
                if (found == 0 && intr[4*d+br]) begin
                    dev = d; found = 1;
                end
            end
        end
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        #1;
        check("rst_inthi", statINTHI, 0);
        check("rst_busintr", busINTR, 0);
        check("rst_devack", devACK, 0);
        check("rst_busy", ackBUSY, 0);
        check("rst_vect", ackVECT, 0);
        tick; tick;
        rst_n = 1'b1;
        model_rr = NDEV - 1;
    endtask

    // mode 0: device replies dly cycles after grant; 1: timeout; 2: statINI abort.
    task automatic do_ack(input int pi, input int mode, input int dly,
                          input logic [15:0] vec, output int got_ack);
        int hit, dev, br;
        predict(devINTR, statPIH, statPIL, pi, hit, dev, br);
        ackREQ = 1'b1; ackPI = 3'(pi);
        tick;
        ackREQ = 1'b0;
        got_ack = devACK;
        check("busy_n1", ackBUSY, 1);
        if (hit == 0) begin
            check("miss_done", ackDONE, 1);
            check("miss_vect", ackVECT, 0);
            check("miss_devack", devACK, 0);
            tick;
            check("miss_done_end", ackDONE, 0);
            return;
        end
        check("grant_dev", devACK, 1 << dev);
        check("grant_br", devACKBR, br);
        check("grant_nodone", ackDONE, 0);
        if (mode == 1) begin
            repeat (TMOCNT) tick;
            check("tmo_still_granted", devACK, 1 << dev);
            check("tmo_early", ackDONE, 0);
            tick;
            check("tmo_done", ackDONE, 1);
            check("tmo_set", setTMO, 1);
            check("tmo_vect", ackVECT, 0);
            check("tmo_devack", devACK, 0);
        end else if (mode == 2) begin
            repeat (dly) tick;
            statINI = 1'b1;
            tick;
            statINI = 1'b0;
            check("ini_done", ackDONE, 1);
            check("ini_tmo", setTMO, 0);
            check("ini_vect", ackVECT, 0);
            check("ini_devack", devACK, 0);
        end else begin
            for (int j = 0; j < dly; j++) begin
                devVECTVLD = (j == 0);
                devVECT    = 16'hdead;
                tick;
                check("wait_granted", devACK, 1 << dev);
                check("wait_nodone", ackDONE, 0);
            end
            devVECTVLD = 1'b1; devVECT = vec;
            tick;
            devVECTVLD = 1'b0; devVECT = 16'h0000;
            check("vld_done", ackDONE, 1);
            check("vld_vect", ackVECT, vec);
            check("vld_tmo", setTMO, 0);
            check("vld_devack", devACK, 0);
            model_rr = dev;
        end
        tick;
        check("done_pulse", ackDONE, 0);
        check("idle_busy", ackBUSY, 0);
        if (mode == 0) check("vect_hold", ackVECT, vec);
    endtask

    initial begin
        int g;
        rst_n = 1'b1; devINTR = 16'h0; statPIH = 3'd0; statPIL = 3'd0;
        statINI = 1'b0; ackREQ = 1'b0; ackPI = 3'd0; devVECTVLD = 1'b0;
        devVECT = 16'h0;
        tick;

        // Reset with requests active, then status follows one cycle later.
        devINTR = 16'h0040; statPIH = 3'd3; statPIL = 3'd5;
        do_reset;
        check("rel_inthi_before", statINTHI, 0);
        tick;
        check("rel_inthi_after", statINTHI, 1);

        // Mapping.
        tick;
        check("map_inthi", statINTHI, 1);
        check("map_intlo", statINTLO, 0);
        check("map_bus1", busINTR, 7'b0000100);
        devINTR = 16'h0140;
        tick;
        check("map_bus2", busINTR, 7'b0010100);
        check("map_intlo2", statINTLO, 1);

        // Vector acknowledge from dev1 BR6.
        devINTR = 16'h0040;
        tick;
        do_ack(3, 0, 2, 16'o254, g);
        check("t3_devack", g, 4'b0010);

        // Priority and round-robin among BR7 requesters.
        do_reset;
        devINTR = 16'h4808;
        tick;
        do_ack(3, 0, 1, 16'h1111, g);
        check("t4_first", g, 4'b0001);
        do_ack(3, 0, 1, 16'h2222, g);
        check("t4_second", g, 4'b0100);
        do_ack(3, 0, 1, 16'h3333, g);
        check("t4_third", g, 4'b0001);

        // Timeout keeps the pointer, so the same device is granted again.
        do_ack(3, 1, 0, 16'h0, g);
        check("t5_tmo_dev", g, 4'b0100);
        do_ack(3, 0, 3, 16'h4444, g);
        check("t5_regrant", g, 4'b0100);

        // PI mismatch and statINI abort.
        do_ack(2, 0, 1, 16'h0, g);
        do_ack(3, 2, 2, 16'h0, g);
        do_ack(3, 2, 0, 16'h0, g);

        // Async reset in the middle of a handshake.
        ackREQ = 1'b1; ackPI = 3'd3;
        tick;
        ackREQ = 1'b0;
        tick; tick;
        do_reset;
        check("midrst_busy", ackBUSY, 0);

        // Randomized traffic.
        for (int it = 0; it < 60; it++) begin
            int pi, mode, dly, r;
            devINTR = ($urandom_range(0, 4) == 0) ? 16'h0 : 16'($urandom & $urandom);
            statPIH = 3'($urandom_range(0, 7));
            statPIL = 3'($urandom_range(0, 7));
            tick;
            check("rnd_inthi", statINTHI, br_any(devINTR, 3) | br_any(devINTR, 2));
            check("rnd_intlo", statINTLO, br_any(devINTR, 1) | br_any(devINTR, 0));
            check("rnd_bus", busINTR, exp_bus(devINTR, statPIH, statPIL));
            r  = $urandom_range(0, 2);
            pi = (r == 0) ? int'(statPIH) : (r == 1) ? int'(statPIL) : $urandom_range(0, 7);
            r  = $urandom_range(0, 11);
            mode = (r == 0) ? 1 : (r < 3) ? 2 : 0;
            dly  = (mode == 2) ? $urandom_range(0, 5) : $urandom_range(1, 6);
            do_ack(pi, mode, dly, 16'($urandom_range(1, 65535)), g);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
